// File: rtl/pipe_pkg.sv
// Shared encodings and payload layout for the inter-stage pipeline register.
// The payload packs {op_a, op_b, imm, rs, rt, rd, shamt} with shamt in the LSBs.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_FULL  = ST_FULL,
        S_SKID  = ST_SKID
    } state_t;

    function automatic int unsigned pay_w(input int unsigned xlen,
                                          input int unsigned ridx_w,
                                          input int unsigned shamt_w);
        return 3 * xlen + 3 * ridx_w + shamt_w;
    endfunction

    function automatic int unsigned off_shamt();
        return 0;
    endfunction

    function automatic int unsigned off_rd(input int unsigned shamt_w);
        return shamt_w;
    endfunction

    function automatic int unsigned off_rt(input int unsigned ridx_w,
                                           input int unsigned shamt_w);
        return shamt_w + ridx_w;
    endfunction

    function automatic int unsigned off_rs(input int unsigned ridx_w,
                                           input int unsigned shamt_w);
        return shamt_w + 2 * ridx_w;
    endfunction

    function automatic int unsigned off_imm(input int unsigned ridx_w,
                                            input int unsigned shamt_w);
        return shamt_w + 3 * ridx_w;
    endfunction

    function automatic int unsigned off_op_b(input int unsigned xlen,
                                             input int unsigned ridx_w,
                                             input int unsigned shamt_w);
        return shamt_w + 3 * ridx_w + xlen;
    endfunction

    function automatic int unsigned off_op_a(input int unsigned xlen,
                                             input int unsigned ridx_w,
                                             input int unsigned shamt_w);
        return shamt_w + 3 * ridx_w + 2 * xlen;
    endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Payload register with synchronous reset, clear-to-NOP and load; reset > clear > load.
module pipe_payload_reg #(
    parameter int unsigned PAY_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [PAY_W-1:0] i_d,
    output logic [PAY_W-1:0] o_q
);

    logic [PAY_W-1:0] r_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_clear) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage MIPS pipeline register with a 2-entry skid buffer, flush-to-bubble
// and a saturating backpressure stall counter. in_ready and out_valid are registered.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RIDX_W  = 5,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_op_a,
    input  logic [XLEN-1:0]    in_op_b,
    input  logic [XLEN-1:0]    in_imm,
    input  logic [RIDX_W-1:0]  in_rs,
    input  logic [RIDX_W-1:0]  in_rt,
    input  logic [RIDX_W-1:0]  in_rd,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_op_a,
    output logic [XLEN-1:0]    out_op_b,
    output logic [XLEN-1:0]    out_imm,
    output logic [RIDX_W-1:0]  out_rs,
    output logic [RIDX_W-1:0]  out_rt,
    output logic [RIDX_W-1:0]  out_rd,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic [CNT_W-1:0]   stall_count
);

    localparam int unsigned PAY_W     = pay_w(XLEN, RIDX_W, SHAMT_W);
    localparam int unsigned OFF_SHAMT = off_shamt();
    localparam int unsigned OFF_RD    = off_rd(SHAMT_W);
    localparam int unsigned OFF_RT    = off_rt(RIDX_W, SHAMT_W);
    localparam int unsigned OFF_RS    = off_rs(RIDX_W, SHAMT_W);
    localparam int unsigned OFF_IMM   = off_imm(RIDX_W, SHAMT_W);
    localparam int unsigned OFF_OP_B  = off_op_b(XLEN, RIDX_W, SHAMT_W);
    localparam int unsigned OFF_OP_A  = off_op_a(XLEN, RIDX_W, SHAMT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [CNT_W-1:0]  r_stall_count;

    logic              w_xfer_in;
    logic              w_xfer_out;
    logic              w_main_load;
    logic              w_main_clear;
    logic              w_main_from_skid;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic [PAY_W-1:0]  w_in_pay;
    logic [PAY_W-1:0]  w_main_d;
    logic [PAY_W-1:0]  w_main_q;
    logic [PAY_W-1:0]  w_skid_q;

    assign w_in_pay   = {in_op_a, in_op_b, in_imm, in_rs, in_rt, in_rd, in_shamt};
    assign w_xfer_in  = in_valid & r_in_ready;
    assign w_xfer_out = r_out_valid & out_ready;
    assign w_main_d   = w_main_from_skid ? w_skid_q : w_in_pay;

    // Next-state and payload-register control; flush wins over any transfer.
    always_comb begin
        w_next_state     = r_state;
        w_main_load      = 1'b0;
        w_main_clear     = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        if (flush) begin
            w_next_state = S_EMPTY;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_xfer_in) begin
                        w_next_state = S_FULL;
                        w_main_load  = 1'b1;
                    end
                end
                S_FULL: begin
                    if (w_xfer_out && w_xfer_in) begin
                        w_main_load  = 1'b1;
                    end else if (w_xfer_out) begin
                        w_next_state = S_EMPTY;
                        w_main_clear = 1'b1;
                    end else if (w_xfer_in) begin
                        w_next_state = S_SKID;
                        w_skid_load  = 1'b1;
                    end
                end
                S_SKID: begin
                    if (w_xfer_out) begin
                        w_next_state     = S_FULL;
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clear     = 1'b1;
                    end
                end
                default: begin
                    w_next_state = S_EMPTY;
                    w_main_clear = 1'b1;
                    w_skid_clear = 1'b1;
                end
            endcase
        end
    end

    // State plus the handshake flags, registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state != S_SKID);
            r_out_valid <= (w_next_state != S_EMPTY);
        end
    end

    // Counts backpressured cycles; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (r_out_valid && !out_ready && (r_stall_count != CNT_MAX)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    pipe_payload_reg #(
        .PAY_W (PAY_W)
    ) u_main (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_d     (w_main_d),
        .o_q     (w_main_q)
    );

    pipe_payload_reg #(
        .PAY_W (PAY_W)
    ) u_skid (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_d     (w_in_pay),
        .o_q     (w_skid_q)
    );

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign stall_count = r_stall_count;
    assign out_op_a    = w_main_q[OFF_OP_A  +: XLEN];
    assign out_op_b    = w_main_q[OFF_OP_B  +: XLEN];
    assign out_imm     = w_main_q[OFF_IMM   +: XLEN];
    assign out_rs      = w_main_q[OFF_RS    +: RIDX_W];
    assign out_rt      = w_main_q[OFF_RT    +: RIDX_W];
    assign out_rd      = w_main_q[OFF_RD    +: RIDX_W];
    assign out_shamt   = w_main_q[OFF_SHAMT +: SHAMT_W];

endmodule
